// File: rtl/bandgap_chop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bandgap_chop_ctrl
// Purpose  : Chopper controller for a chopped bandgap. Generates the two
//            non-overlapping chopper phases and demodulates the comparator
//            bit returned by the analog core. The demodulated bits are
//            integrated into a saturated signed 8-bit trim result.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous reset, active low
//   ena          in   1      enable; 0 clears the timebase and integrator
//                            (result holds)
//   div_sel      in   DIV_W  half-period select: half = HALF_BASE << div_sel
//   dead_sel     in   2      dead time = 1 << dead_sel cycles
//   cmp_in       in   1      asynchronous comparator bit from analog core
//   phi1         out  1      chopper phase A switch drive
//   phi2         out  1      chopper phase B switch drive
//   chop_sync    out  1      1-cycle pulse at the start of each phase A
//   result       out  8      signed demodulated sum, saturated
//   result_valid out  1      1-cycle strobe when result updates
// Configuration
//   CHOP_SPREAD_EN : when defined, a 4-bit LFSR (x^4+x^3+1, seed 4'b1001)
//                    adds lfsr[1:0] to every half-period to spread chop tones.
// ============================================================================
module bandgap_chop_ctrl #(
    parameter int HALF_BASE = 4,
    parameter int N_LOG2    = 6,
    parameter int DIV_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] div_sel,
    input  logic [1:0]       dead_sel,
    input  logic             cmp_in,
    output logic             phi1,
    output logic             phi2,
    output logic             chop_sync,
    output logic [7:0]       result,
    output logic             result_valid
);

    // Counter sized for the largest half-period including the spread offset.
    localparam int MAX_HALF = (HALF_BASE << ((1 << DIV_W) - 1)) + 3;
    localparam int CNT_W    = $clog2(MAX_HALF + 1);
    localparam int ACC_W    = N_LOG2 + 3;

    localparam logic signed [ACC_W-1:0] c_SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_SAT_LO = -ACC_W'(128);

    typedef enum logic [0:0] {
        PH_A = 1'b0,
        PH_B = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [1:0]                dsel_q, dsel_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [N_LOG2-1:0]         per_q, per_d;
    logic                      sync1_q, cmp_s_q;
    logic                      phi1_q, phi1_d;
    logic                      phi2_q, phi2_d;
    logic                      csync_q, csync_d;
    logic [7:0]                result_q, result_d;
    logic                      valid_q, valid_d;
`ifdef CHOP_SPREAD_EN
    logic [3:0]                lfsr_q, lfsr_d;
`endif

    logic [CNT_W-1:0]          w_half;
    logic [CNT_W+3:0]          w_dead_raw;
    logic [CNT_W-1:0]          w_dead;
    logic                      w_end;
    logic                      w_up;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic [7:0]                w_sat;

    // Timebase derived from the values latched at the start of phase A, so a
    // mid-period change to div_sel/dead_sel never produces a runt pulse.
    always_comb begin
`ifdef CHOP_SPREAD_EN
        w_half = (CNT_W'(HALF_BASE) << div_q) + CNT_W'(lfsr_q[1:0]);
`else
        w_half = CNT_W'(HALF_BASE) << div_q;
`endif
        w_dead_raw = (CNT_W+4)'(1) << dsel_q;
        // Clamp keeps at least one active cycle per phase.
        if (w_dead_raw >= {4'b0000, w_half}) begin
            w_dead = w_half - CNT_W'(1);
        end else begin
            w_dead = w_dead_raw[CNT_W-1:0];
        end
        w_end = (cnt_q == (w_half - CNT_W'(1)));
        // Demodulation: +1 when the comparator agrees with the current phase.
        w_up       = cmp_s_q ^ (state_q == PH_B);
        w_acc_next = acc_q + (w_up ? ACC_W'(1) : {ACC_W{1'b1}});
        if (w_acc_next > c_SAT_HI) begin
            w_sat = 8'h7F;
        end else if (w_acc_next < c_SAT_LO) begin
            w_sat = 8'h80;
        end else begin
            w_sat = w_acc_next[7:0];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dsel_d   = dsel_q;
        acc_d    = acc_q;
        per_d    = per_q;
        result_d = result_q;
        valid_d  = 1'b0;
        phi1_d   = 1'b0;
        phi2_d   = 1'b0;
        csync_d  = 1'b0;
`ifdef CHOP_SPREAD_EN
        lfsr_d   = lfsr_q;
`endif
        if (!ena) begin
            state_d = PH_A;
            cnt_d   = '0;
            acc_d   = '0;
            per_d   = '0;
        end else begin
            phi1_d  = (state_q == PH_A) && (cnt_q >= w_dead);
            phi2_d  = (state_q == PH_B) && (cnt_q >= w_dead);
            csync_d = (state_q == PH_A) && (cnt_q == '0);
            if ((state_q == PH_A) && (cnt_q == '0)) begin
                div_d  = div_sel;
                dsel_d = dead_sel;
            end
            if (w_end) begin
                cnt_d = '0;
                acc_d = w_acc_next;
`ifdef CHOP_SPREAD_EN
                lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
`endif
                if (state_q == PH_A) begin
                    state_d = PH_B;
                end else begin
                    state_d = PH_A;
                    per_d   = per_q + N_LOG2'(1);
                    // Frame closes on the phase-B sample of the last period;
                    // the next frame starts on the same edge.
                    if (per_q == '1) begin
                        result_d = w_sat;
                        valid_d  = 1'b1;
                        acc_d    = '0;
                        per_d    = '0;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PH_A;
            cnt_q    <= '0;
            div_q    <= '0;
            dsel_q   <= '0;
            acc_q    <= '0;
            per_q    <= '0;
            sync1_q  <= 1'b0;
            cmp_s_q  <= 1'b0;
            phi1_q   <= 1'b0;
            phi2_q   <= 1'b0;
            csync_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef CHOP_SPREAD_EN
            lfsr_q   <= 4'b1001;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dsel_q   <= dsel_d;
            acc_q    <= acc_d;
            per_q    <= per_d;
            sync1_q  <= cmp_in;
            cmp_s_q  <= sync1_q;
            phi1_q   <= phi1_d;
            phi2_q   <= phi2_d;
            csync_q  <= csync_d;
            result_q <= result_d;
            valid_q  <= valid_d;
`ifdef CHOP_SPREAD_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign phi1         = phi1_q;
    assign phi2         = phi2_q;
    assign chop_sync    = csync_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule
`default_nettype wire
